// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between one master and a memory slave.
// HREADY is the bus-level ready; in a single-slave system it is tied to HREADYOUT.
interface ahb_lite_mem_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        input  HREADY, HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-organised memory slave with programmable wait states and
// the two-cycle ERROR response for illegal size, alignment or address range.
module ahb_lite_mem_slave #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_lite_mem_slave_if.slave bus
);
    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_WORDS);
    localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt, wait_cnt_nxt;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [31:0]   mem [MEM_WORDS];

    logic          ready;
    logic          resp;
    logic          accept;
    logic          legal;
    logic          mem_we;
    logic [3:0]    byte_en;
    logic [AW-1:0] word_idx;
    logic          unused_bits;

    function automatic logic is_legal(input logic [31:0] addr, input logic [2:0] size);
        logic ok;
        ok = 1'b1;
        if (size > 3'd2)                          ok = 1'b0;
        if ((size == 3'd1) && addr[0])            ok = 1'b0;
        if ((size == 3'd2) && (addr[1:0] != 2'b00)) ok = 1'b0;
        if ({1'b0, addr} >= MEM_BYTES)            ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] ofs);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << ofs;
            3'd1:    m = ofs[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Address phases are only sampled in cycles where this slave is not stalling.
    assign accept = ((state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2)) &&
                    bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign legal  = is_legal(bus.HADDR, bus.HSIZE);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ready        = 1'b1;
        resp         = 1'b0;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                resp = (state == ST_ERR2);
                if (accept) begin
                    if (!legal)                state_nxt = ST_ERR1;
                    else if (WAIT_STATES > 0)  state_nxt = ST_WAIT;
                    else                       state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                ready = 1'b0;
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = ST_DATA;
                    wait_cnt_nxt = 4'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            ST_ERR1: begin
                ready     = 1'b0;
                resp      = 1'b1;
                state_nxt = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                addr_q  <= bus.HADDR[AW+1:0];
                write_q <= bus.HWRITE;
                size_q  <= bus.HSIZE;
            end
        end
    end

    assign word_idx = addr_q[AW+1:2];
    assign byte_en  = lane_mask(size_q, addr_q[1:0]);
    // HRESETn gating keeps a reset that lands on a DATA-cycle edge from committing the write.
    assign mem_we   = HRESETn && (state == ST_DATA) && write_q;

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    assign bus.HRDATA    = ((state == ST_DATA) && !write_q) ? mem[word_idx] : 32'd0;
    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;

    assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};
endmodule
